// File: rtl/fft_out_reorder.sv
// Output reorder buffer: turns bit-reversed 64-point FFT frames into natural order.
// Latency: X[0] appears two edges after the last input sample is captured.
// Backpressure: none; ping-pong banks let the reader drain one frame while the next fills.
module fft_out_reorder #(
  parameter int WIDTH  = 17,
  parameter int N_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic [WIDTH-1:0] data_in_re,
  input  logic [WIDTH-1:0] data_in_im,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [WIDTH-1:0] data_out_re,
  output logic [WIDTH-1:0] data_out_im,
  output logic             frame_err
);

  localparam int DEPTH = 2 << N_LOG2;

  typedef enum logic { W_IDLE, W_FILL } wstate_t;
  typedef enum logic { R_IDLE, R_READ } rstate_t;

  wstate_t             wstate;
  rstate_t             rstate;
  logic [N_LOG2-1:0]   wcnt;
  logic [N_LOG2-1:0]   rcnt;
  logic                wbank;
  logic                rbank;
  logic [1:0]          full;

  // Bank memory is addressed as {bank, address}; contents survive reset as don't-care.
  logic [WIDTH-1:0]    mem_re [DEPTH];
  logic [WIDTH-1:0]    mem_im [DEPTH];

  logic                wr_start;
  logic                wr_en;
  logic                wr_done;
  logic                early_sop;
  logic [N_LOG2-1:0]   wr_addr;
  logic                rd_last;
  logic                other_full;
  logic                bank_conflict;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = a[N_LOG2-1-i];
    return r;
  endfunction

  // Write-side decode: a sop always restarts at address 0 of the current bank.
  always_comb begin
    wr_start   = in_valid && in_sop;
    early_sop  = (wstate == W_FILL) && wr_start && (wcnt != '0);
    wr_en      = in_valid && (wr_start || (wstate == W_FILL));
    wr_addr    = wr_start ? '0 : wcnt;
    wr_done    = wr_en && !wr_start && (wcnt == '1);
    rd_last    = (rstate == R_READ) && (rcnt == '1);
    // A bank completing on the reader's last cycle still counts, so frames stay back-to-back.
    other_full = full[!rbank] || (wr_done && (wbank == !rbank));
    bank_conflict = wr_en && full[wbank] && !(rd_last && (rbank == wbank));
  end

  // Writer FSM: fill the current bank in stream order, flip banks on the 64th sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate    <= W_IDLE;
      wcnt      <= '0;
      wbank     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= early_sop;
      if (wr_en) begin
        if (wr_start) begin
          wcnt   <= N_LOG2'(1);
          wstate <= W_FILL;
        end else if (wr_done) begin
          wcnt   <= '0;
          wbank  <= ~wbank;
          wstate <= W_IDLE;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
    end
  end

  // Sample storage; no reset needed on the data array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[{wbank, wr_addr}] <= data_in_re;
      mem_im[{wbank, wr_addr}] <= data_in_im;
    end
  end

  // Full flags: set by the writer on frame completion, cleared by the reader after its last read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_done && (wbank == 1'(b)))
          full[b] <= 1'b1;
        else if (rd_last && (rbank == 1'(b)))
          full[b] <= 1'b0;
      end
    end
  end

  // Reader FSM: banks are drained in fill order, reading bit-reversed addresses into output regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate      <= R_IDLE;
      rcnt        <= '0;
      rbank       <= 1'b0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      data_out_re <= '0;
      data_out_im <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          out_valid <= 1'b0;
          out_sop   <= 1'b0;
          out_eop   <= 1'b0;
          if (full[rbank]) begin
            rcnt   <= '0;
            rstate <= R_READ;
          end
        end
        default: begin
          data_out_re <= mem_re[{rbank, bitrev(rcnt)}];
          data_out_im <= mem_im[{rbank, bitrev(rcnt)}];
          out_valid   <= 1'b1;
          out_sop     <= (rcnt == '0);
          out_eop     <= rd_last;
          rcnt        <= rcnt + 1'b1;
          if (rd_last) begin
            rbank <= ~rbank;
            if (!other_full) rstate <= R_IDLE;
          end
        end
      endcase
    end
  end

  // Simulation-only guard: overwriting a bank the reader has not drained is a design error.
  assert property (@(posedge clk) disable iff (!rst_n) !bank_conflict)
    else $fatal(1, "fft_out_reorder: write into a full bank");

endmodule
